// File: rtl/counter_job_ctrl_pkg.sv
// Shared types for the counter job controller: FSM states, direction encoding
// and the captured-job record.
package counter_ctrl_pkg;

    localparam int JOB_N_REQ  = 4;
    localparam int JOB_WIDTH  = 8;
    localparam int JOB_STEP_W = 8;
    localparam int JOB_ID_W   = (JOB_N_REQ > 1) ? $clog2(JOB_N_REQ) : 1;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } state_t;

    // Field widths track the package defaults, which the controller's
    // parameters default to.
    typedef struct packed {
        logic [JOB_WIDTH-1:0]  start;
        logic [JOB_STEP_W-1:0] steps;
        logic                  dir;
        logic [JOB_ID_W-1:0]   id;
    } job_t;

endpackage

// File: rtl/counter_job_ctrl_if.sv
// Requester/consumer handshake bundle of the counter job controller.
// master = requesters and result consumer, slave = the controller.
interface counter_job_ctrl_if #(
    parameter int N_REQ  = 4,
    parameter int WIDTH  = 8,
    parameter int STEP_W = 8
) ();
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*WIDTH-1:0]  req_start;
    logic [N_REQ*STEP_W-1:0] req_steps;
    logic [N_REQ-1:0]        req_dir;
    logic [N_REQ-1:0]        req_ready;
    logic                    rsp_valid;
    logic [ID_W-1:0]         rsp_id;
    logic [WIDTH-1:0]        rsp_count;
    logic                    rsp_ready;

    modport master (
        output req_valid, req_start, req_steps, req_dir, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_count
    );

    modport slave (
        input  req_valid, req_start, req_steps, req_dir, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_count
    );
endinterface

// File: rtl/counter_job_ctrl_rr_arbiter.sv
// Round-robin arbiter: picks the first request at or after the pointer,
// wrapping, and moves the pointer past the winner when the grant is accepted.
module rr_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic             accept,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    always_comb begin
        logic [IDX_W:0] cand;
        cand    = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, r_ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(N)) begin
                cand = cand - (IDX_W+1)'(N);
            end
            if (!w_found && req[cand[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_idx   = cand[IDX_W-1:0];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_grant
            assign grant[gi] = w_found && (w_idx == IDX_W'(gi));
        end
    endgenerate

    assign grant_idx   = w_idx;
    assign grant_valid = w_found;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= '0;
        end else if (accept && w_found) begin
            r_ptr <= (w_idx == IDX_W'(N-1)) ? '0 : w_idx + 1'b1;
        end
    end

endmodule

// File: rtl/counter_job_ctrl.sv
// Job sequencer for a shared up/down counter: arbitrates requesters, loads and
// steps the counter, then returns the final count tagged with the requester id.
module counter_job_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int N_REQ  = JOB_N_REQ,
    parameter int WIDTH  = JOB_WIDTH,
    parameter int STEP_W = JOB_STEP_W
) (
    input  logic                clk,
    input  logic                reset,
    counter_job_ctrl_if.slave   bus,
    output logic                busy,
    output logic                cnt_load,
    output logic                cnt_enable,
    output logic                cnt_inc,
    output logic                cnt_dec,
    output logic [WIDTH-1:0]    cnt_din,
    input  logic [WIDTH-1:0]    cnt_count
);

    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t            r_state;
    job_t              r_job;
    logic [STEP_W-1:0] r_remaining;
    logic              r_arb_en;
    logic              r_busy;
    logic              r_cnt_load;
    logic              r_cnt_enable;
    logic              r_cnt_inc;
    logic              r_cnt_dec;
    logic [WIDTH-1:0]  r_cnt_din;
    logic              r_rsp_valid;
    logic [ID_W-1:0]   r_rsp_id;

    logic [N_REQ-1:0]  w_grant;
    logic [ID_W-1:0]   w_gidx;
    logic              w_gvalid;
    logic              w_accept;

    // r_arb_en keeps req_ready low while reset is asserted and until the
    // first clock after release.
    assign w_accept = r_arb_en && (r_state == IDLE) && w_gvalid;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .clk         (clk),
        .reset       (reset),
        .req         (bus.req_valid),
        .accept      (w_accept),
        .grant       (w_grant),
        .grant_idx   (w_gidx),
        .grant_valid (w_gvalid)
    );

    assign bus.req_ready = w_accept ? w_grant : '0;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    // The counter is idle in RESP, so its output is stable without a copy.
    assign bus.rsp_count = (r_state == RESP) ? cnt_count : '0;

    assign busy       = r_busy;
    assign cnt_load   = r_cnt_load;
    assign cnt_enable = r_cnt_enable;
    assign cnt_inc    = r_cnt_inc;
    assign cnt_dec    = r_cnt_dec;
    assign cnt_din    = r_cnt_din;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_job        <= '0;
            r_remaining  <= '0;
            r_arb_en     <= 1'b0;
            r_busy       <= 1'b0;
            r_cnt_load   <= 1'b0;
            r_cnt_enable <= 1'b0;
            r_cnt_inc    <= 1'b0;
            r_cnt_dec    <= 1'b0;
            r_cnt_din    <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
        end else begin
            r_arb_en <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_job.start <= bus.req_start[w_gidx*WIDTH +: WIDTH];
                        r_job.steps <= bus.req_steps[w_gidx*STEP_W +: STEP_W];
                        r_job.dir   <= bus.req_dir[w_gidx];
                        r_job.id    <= w_gidx;
                        r_busy      <= 1'b1;
                        r_cnt_load  <= 1'b1;
                        r_cnt_din   <= bus.req_start[w_gidx*WIDTH +: WIDTH];
                        r_state     <= LOAD;
                    end
                end
                LOAD: begin
                    r_cnt_load  <= 1'b0;
                    r_remaining <= r_job.steps;
                    if (r_job.steps != '0) begin
                        r_cnt_enable <= 1'b1;
                        r_cnt_inc    <= (r_job.dir == DIR_UP);
                        r_cnt_dec    <= (r_job.dir == DIR_DOWN);
                        r_state      <= RUN;
                    end else begin
                        r_cnt_din   <= '0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_id    <= r_job.id;
                        r_state     <= RESP;
                    end
                end
                RUN: begin
                    r_remaining <= r_remaining - 1'b1;
                    if (r_remaining == STEP_W'(1)) begin
                        r_cnt_enable <= 1'b0;
                        r_cnt_inc    <= 1'b0;
                        r_cnt_dec    <= 1'b0;
                        r_cnt_din    <= '0;
                        r_rsp_valid  <= 1'b1;
                        r_rsp_id     <= r_job.id;
                        r_state      <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_id    <= '0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
